// File: rtl/uart_tx_frame.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_frame
// Function : UART transmitter, start / 8 data LSB-first / optional parity /
//            1-or-2 stop bits, with its own baud-period divider.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_frame #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DIV_W    = 15
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic [1:0] BaudRate,
  input  logic [1:0] ParityType,
  input  logic       StopBits,
  input  logic [7:0] DataIn,
  input  logic       Send,
  output logic       DataTx,
  output logic       Busy,
  output logic       Done
);

  // Divisors rounded to nearest: round(CLK_FREQ / baud)
  localparam int c_div2400  = (CLK_FREQ + 1200) / 2400;
  localparam int c_div4800  = (CLK_FREQ + 2400) / 4800;
  localparam int c_div9600  = (CLK_FREQ + 4800) / 9600;
  localparam int c_div19200 = (CLK_FREQ + 9600) / 19200;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_bitCnt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitIdx;
  logic             r_parityEn;
  logic             r_parityBit;
  logic             r_twoStop;
  logic             r_stopIdx;
  logic             r_dataTx;
  logic             r_busy;
  logic             r_done;

  logic [DIV_W-1:0] w_div;
  logic             w_parityEn;
  logic             w_parityBit;
  logic             w_lastTick;
  logic             w_doneNext;

  always_comb begin
    w_div = DIV_W'(c_div2400);
    case (BaudRate)
      2'b00:   w_div = DIV_W'(c_div2400);
      2'b01:   w_div = DIV_W'(c_div4800);
      2'b10:   w_div = DIV_W'(c_div9600);
      default: w_div = DIV_W'(c_div19200);
    endcase
  end

  assign w_parityEn  = (ParityType == 2'b01) || (ParityType == 2'b10);
  assign w_parityBit = (ParityType == 2'b01) ? ~^DataIn : ^DataIn;
  assign w_lastTick  = (r_bitCnt == r_div - DIV_W'(1));
  // Done is registered, so raise it one tick early to land on the final clock
  assign w_doneNext  = (r_state == S_STOP) && (r_stopIdx == r_twoStop) &&
                       (r_bitCnt == r_div - DIV_W'(2));

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_bitIdx    <= '0;
      r_parityEn  <= 1'b0;
      r_parityBit <= 1'b0;
      r_twoStop   <= 1'b0;
      r_stopIdx   <= 1'b0;
      r_dataTx    <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done   <= w_doneNext;
      r_bitCnt <= w_lastTick ? '0 : r_bitCnt + DIV_W'(1);
      case (r_state)
        S_IDLE: begin
          r_bitCnt <= '0;
          r_dataTx <= 1'b1;
          r_busy   <= 1'b0;
          if (Send) begin
            r_state     <= S_START;
            r_div       <= w_div;
            r_shift     <= DataIn;
            r_parityEn  <= w_parityEn;
            r_parityBit <= w_parityBit;
            r_twoStop   <= StopBits;
            r_dataTx    <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_START: begin
          if (w_lastTick) begin
            r_state  <= S_DATA;
            r_bitIdx <= 3'd0;
            r_dataTx <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_lastTick) begin
            r_bitIdx <= r_bitIdx + 3'd1;
            r_shift  <= {1'b0, r_shift[7:1]};
            if (r_bitIdx == 3'd7) begin
              if (r_parityEn) begin
                r_state  <= S_PARITY;
                r_dataTx <= r_parityBit;
              end else begin
                r_state   <= S_STOP;
                r_stopIdx <= 1'b0;
                r_dataTx  <= 1'b1;
              end
            end else begin
              r_dataTx <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_lastTick) begin
            r_state   <= S_STOP;
            r_stopIdx <= 1'b0;
            r_dataTx  <= 1'b1;
          end
        end
        S_STOP: begin
          r_dataTx <= 1'b1;
          if (w_lastTick) begin
            if (r_stopIdx == r_twoStop) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_stopIdx <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_dataTx <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign DataTx = r_dataTx;
  assign Busy   = r_busy;
  assign Done   = r_done;

endmodule

`default_nettype wire
